sram_id_match_engine: RTL and testbench

Parametrised multi-beat ID lookup engine for the SRAM process table. It accepts one packet ID per request, then scans BEATS rows of ENTRIES stored IDs streamed from the SRAM reader. It returns the lowest-index matching slot and the lowest-index free (zero) slot through a valid/ready result interface. It replaces the fixed 14-lane single-row comparator and sits between the packet-ID extractor and the table update logic.

---
 rtl/sram_id_match_engine.sv | 181 ++++++++++++++++++
 tb/tb_sram_id_match_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_id_match_engine.sv
// Multi-beat SRAM ID lookup: lowest matching slot and lowest free slot across BEATS rows of ENTRIES IDs.
// Latency: result valid 2 cycles after the last beat. Optional duplicate counter under SRAM_ID_MULTI_HIT_EN.
module sram_id_match_engine #(
    parameter int ID_W    = 16,
    parameter int ENTRIES = 14,
    parameter int BEATS   = 4,
    parameter int IDX_W   = $clog2(ENTRIES*BEATS),
    parameter int CNT_W   = $clog2(ENTRIES*BEATS+1)
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [ID_W-1:0]         i_req_id,
    input  logic                    i_row_valid,
    output logic                    o_row_ready,
    input  logic [ENTRIES*ID_W-1:0] i_row_data,
    input  logic [ENTRIES-1:0]      i_row_ena,
    output logic                    o_res_valid,
    input  logic                    i_res_ready,
    output logic                    o_res_hit,
    output logic [IDX_W-1:0]        o_res_hit_idx,
    output logic                    o_res_free,
    output logic [IDX_W-1:0]        o_res_free_idx,
    output logic                    o_res_multi_hit,
    output logic [CNT_W-1:0]        o_res_hit_count
);
    localparam int LANE_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_req_rdy;
    logic [ID_W-1:0]          r_key;
    logic [BEAT_W-1:0]        r_beat_cnt;
    logic                     r_cmp_vld;
    logic [BEAT_W-1:0]        r_cmp_beat;
    logic [ENTRIES-1:0][1:0]  r_codes;
    logic [ENTRIES-1:0][1:0]  w_codes;
    logic                     r_hit;
    logic                     r_free;
    logic [IDX_W-1:0]         r_hit_idx;
    logic [IDX_W-1:0]         r_free_idx;
    logic                     w_req_acc;
    logic                     w_row_acc;
    logic                     w_last_beat;
    logic                     w_beat_hit;
    logic                     w_beat_free;
    logic [LANE_W-1:0]        w_hit_lane;
    logic [LANE_W-1:0]        w_free_lane;
    logic [IDX_W-1:0]         w_base;

    assign w_req_acc   = r_req_rdy & i_req_valid;
    assign w_row_acc   = (r_state == SCAN) & i_row_valid;
    assign w_last_beat = (r_beat_cnt == BEAT_W'(BEATS-1));

    // DRAIN holds until the last registered compare has been merged, so DONE sees final results
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req_acc) w_state_nxt = SCAN;
            SCAN:    if (w_row_acc && w_last_beat) w_state_nxt = DRAIN;
            DRAIN:   if (!r_cmp_vld) w_state_nxt = DONE;
            DONE:    if (i_res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Lane code: 1 = enabled match (never for a zero key), 2 = enabled zero, 0 = nothing
    always_comb begin
        w_codes = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            if (i_row_ena[k]) begin
                if ((r_key != '0) && (i_row_data[k*ID_W +: ID_W] == r_key))
                    w_codes[k] = 2'd1;
                else if (i_row_data[k*ID_W +: ID_W] == '0)
                    w_codes[k] = 2'd2;
            end
        end
    end

    always_comb begin
        w_beat_hit  = 1'b0;
        w_beat_free = 1'b0;
        w_hit_lane  = '0;
        w_free_lane = '0;
        for (int k = ENTRIES-1; k >= 0; k--) begin
            if (r_codes[k] == 2'd1) begin
                w_beat_hit = 1'b1;
                w_hit_lane = LANE_W'(k);
            end
            if (r_codes[k] == 2'd2) begin
                w_beat_free = 1'b1;
                w_free_lane = LANE_W'(k);
            end
        end
    end

    assign w_base = IDX_W'(r_cmp_beat) * IDX_W'(ENTRIES);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_req_rdy  <= 1'b0;
            r_key      <= '0;
            r_beat_cnt <= '0;
            r_cmp_vld  <= 1'b0;
            r_cmp_beat <= '0;
            r_codes    <= '0;
            r_hit      <= 1'b0;
            r_hit_idx  <= '0;
            r_free     <= 1'b0;
            r_free_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_req_rdy <= (w_state_nxt == IDLE);
            r_cmp_vld <= w_row_acc;
            if (w_row_acc) begin
                r_codes    <= w_codes;
                r_cmp_beat <= r_beat_cnt;
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
            if (w_req_acc) begin
                r_key      <= i_req_id;
                r_beat_cnt <= '0;
                r_hit      <= 1'b0;
                r_hit_idx  <= '0;
                r_free     <= 1'b0;
                r_free_idx <= '0;
            end else if (r_cmp_vld) begin
                // Beats arrive in order, so the first hit/free seen is the lowest slot
                if (!r_hit && w_beat_hit) begin
                    r_hit     <= 1'b1;
                    r_hit_idx <= w_base + IDX_W'(w_hit_lane);
                end
                if (!r_free && w_beat_free) begin
                    r_free     <= 1'b1;
                    r_free_idx <= w_base + IDX_W'(w_free_lane);
                end
            end
        end
    end

`ifdef SRAM_ID_MULTI_HIT_EN
    logic [CNT_W-1:0] r_hit_count;
    logic [CNT_W-1:0] w_beat_hits;

    always_comb begin
        w_beat_hits = '0;
        for (int k = 0; k < ENTRIES; k++) begin
            if (r_codes[k] == 2'd1) w_beat_hits = w_beat_hits + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hit_count <= '0;
        end else if (w_req_acc) begin
            r_hit_count <= '0;
        end else if (r_cmp_vld) begin
            r_hit_count <= r_hit_count + w_beat_hits;
        end
    end

    assign o_res_hit_count = r_hit_count;
    assign o_res_multi_hit = (r_hit_count > CNT_W'(1));
`else
    assign o_res_hit_count = '0;
    assign o_res_multi_hit = 1'b0;
`endif

    assign o_req_ready    = r_req_rdy;
    assign o_row_ready    = (r_state == SCAN);
    assign o_res_valid    = (r_state == DONE);
    assign o_res_hit      = r_hit;
    assign o_res_hit_idx  = r_hit_idx;
    assign o_res_free     = r_free;
    assign o_res_free_idx = r_free_idx;
endmodule

// File: tb/tb_sram_id_match_engine.sv
// Bench for sram_id_match_engine: directed vector table, reset/stall sequences, random lookups vs slot-level model.
module tb_sram_id_match_engine;
    localparam int ID_W    = 16;
    localparam int ENTRIES = 14;
    localparam int BEATS   = 4;
    localparam int SLOTS   = ENTRIES*BEATS;
    localparam int IDX_W   = $clog2(SLOTS);
    localparam int CNT_W   = $clog2(SLOTS+1);
`ifdef SRAM_ID_MULTI_HIT_EN
    localparam bit MH = 1'b1;
`else
    localparam bit MH = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req_valid, req_ready, row_valid, row_ready;
    logic [ID_W-1:0]         req_id;
    logic [ENTRIES*ID_W-1:0] row_data;
    logic [ENTRIES-1:0]      row_ena;
    logic                    res_valid, res_ready, res_hit, res_free, res_multi;
    logic [IDX_W-1:0]        res_hit_idx, res_free_idx;
    logic [CNT_W-1:0]        res_cnt;

    always #5 clk = ~clk;

    sram_id_match_engine #(.ID_W(ID_W), .ENTRIES(ENTRIES), .BEATS(BEATS)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_id(req_id),
        .i_row_valid(row_valid), .o_row_ready(row_ready), .i_row_data(row_data), .i_row_ena(row_ena),
        .o_res_valid(res_valid), .i_res_ready(res_ready),
        .o_res_hit(res_hit), .o_res_hit_idx(res_hit_idx),
        .o_res_free(res_free), .o_res_free_idx(res_free_idx),
        .o_res_multi_hit(res_multi), .o_res_hit_count(res_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [ID_W-1:0] g_ids [SLOTS];
    bit              g_ena [SLOTS];

    typedef struct {
        string           name;
        logic [ID_W-1:0] key;
        int              ps [4];
        logic [ID_W-1:0] pv [4];
        int              ds [2];
        int              gap, hold;
        bit              eh;
        int              ehi;
        bit              ef;
        int              efi;
        int              ec;
    } vec_t;
    vec_t vt [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tfail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait expired, required handshake never seen", nm);
    endtask

    function automatic vec_t mk(input string nm, input logic [ID_W-1:0] key,
                                input int s0, input logic [ID_W-1:0] v0, input int s1, input logic [ID_W-1:0] v1,
                                input int s2, input logic [ID_W-1:0] v2, input int s3, input logic [ID_W-1:0] v3,
                                input int d0, input int d1, input int gap, input int hold,
                                input bit eh, input int ehi, input bit ef, input int efi, input int ec);
        vec_t v;
        v.name = nm; v.key = key;
        v.ps[0] = s0; v.pv[0] = v0; v.ps[1] = s1; v.pv[1] = v1;
        v.ps[2] = s2; v.pv[2] = v2; v.ps[3] = s3; v.pv[3] = v3;
        v.ds[0] = d0; v.ds[1] = d1; v.gap = gap; v.hold = hold;
        v.eh = eh; v.ehi = ehi; v.ef = ef; v.efi = efi; v.ec = ec;
        return v;
    endfunction

    // Background IDs are 0x80xx: never zero and never equal to a directed key
    task automatic fill_bg();
        for (int s = 0; s < SLOTS; s++) begin
            g_ids[s] = 16'h8000 | ID_W'(s);
            g_ena[s] = 1'b1;
        end
    endtask

    task automatic model(input logic [ID_W-1:0] key, output bit h, output int hi,
                         output bit f, output int fi, output int c);
        h = 0; hi = 0; f = 0; fi = 0; c = 0;
        for (int s = 0; s < SLOTS; s++) begin
            if (g_ena[s] && key != 0 && g_ids[s] == key) begin
                c++;
                if (!h) begin h = 1; hi = s; end
            end else if (g_ena[s] && g_ids[s] == 0 && !f) begin
                f = 1; fi = s;
            end
        end
    endtask

    task automatic send_row(input string tag, input logic [ENTRIES*ID_W-1:0] d, input logic [ENTRIES-1:0] e);
        int to;
        row_data = d; row_ena = e; row_valid = 1'b1; to = 0;
        while (!row_ready && to < 100) begin tick(); to++; end
        if (to >= 100) tfail({tag, " row_ready"});
        else tick();
        row_valid = 1'b0;
    endtask

    task automatic start_req(input string tag, input logic [ID_W-1:0] key);
        int to;
        req_id = key; req_valid = 1'b1; to = 0;
        while (!req_ready && to < 100) begin tick(); to++; end
        if (to >= 100) tfail({tag, " req_ready"});
        else tick();
        req_valid = 1'b0;
    endtask

    task automatic send_beat_of(input string tag, input int b);
        logic [ENTRIES*ID_W-1:0] d;
        logic [ENTRIES-1:0]      e;
        for (int k = 0; k < ENTRIES; k++) begin
            d[k*ID_W +: ID_W] = g_ids[b*ENTRIES+k];
            e[k] = g_ena[b*ENTRIES+k];
        end
        send_row(tag, d, e);
    endtask

    task automatic run_lookup(input string tag, input logic [ID_W-1:0] key, input int gap, input int hold,
                              input bit eh, input int ehi, input bit ef, input int efi, input int ec);
        logic [20:0] exp_pk;
        bit em;
        int ecnt;
        em = MH && (ec > 1);
        ecnt = MH ? ec : 0;
        exp_pk = {eh, IDX_W'(ehi), ef, IDX_W'(efi), em, CNT_W'(ecnt)};
        start_req(tag, key);
        chk({tag, " row_ready after accept"}, row_ready, 1);
        for (int b = 0; b < BEATS; b++) begin
            repeat (gap) tick();
            send_beat_of(tag, b);
        end
        chk({tag, " res_valid at T1"}, res_valid, 0);
        chk({tag, " row_ready after last beat"}, row_ready, 0);
        tick();
        chk({tag, " res_valid at T1+1"}, res_valid, 0);
        tick();
        chk({tag, " res_valid at T1+2"}, res_valid, 1);
        for (int h = 0; h < hold; h++) begin
            row_valid = 1'b1; row_data = {ENTRIES{key}}; row_ena = '1;
            req_valid = 1'b1; req_id = key ^ 16'h0F0F;
            chk({tag, " held result"}, {res_hit, res_hit_idx, res_free, res_free_idx, res_multi, res_cnt}, exp_pk);
            chk({tag, " held req_ready"}, req_ready, 0);
            chk({tag, " held row_ready"}, row_ready, 0);
            chk({tag, " held res_valid"}, res_valid, 1);
            tick();
        end
        row_valid = 1'b0; req_valid = 1'b0;
        chk({tag, " res_hit"}, res_hit, eh);
        chk({tag, " res_hit_idx"}, res_hit_idx, ehi);
        chk({tag, " res_free"}, res_free, ef);
        chk({tag, " res_free_idx"}, res_free_idx, efi);
        chk({tag, " res_multi_hit"}, res_multi, em);
        chk({tag, " res_hit_count"}, res_cnt, ecnt);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, " res_valid after handshake"}, res_valid, 0);
        chk({tag, " req_ready after handshake"}, req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        bit h, f;
        int hi, fi, c, gap, hold;
        logic [ID_W-1:0] key;

        vt[0] = mk("single_hit", 16'h1234, 33, 16'h1234, -1, 0, -1, 0, -1, 0, -1, -1, 0, 0, 1, 33, 0, 0, 1);
        vt[1] = mk("free_slot", 16'hBEEF, 14, 16'h0000, 44, 16'h0000, -1, 0, -1, 0, -1, -1, 0, 0, 0, 0, 1, 14, 0);
        vt[2] = mk("ena_mask", 16'h5555, 3, 16'h5555, 7, 16'h5555, 10, 16'h0000, 20, 16'h0000, 3, 10, 0, 0, 1, 7, 1, 20, 1);
        vt[3] = mk("key_zero", 16'h0000, 9, 16'h0000, 50, 16'h0000, -1, 0, -1, 0, -1, -1, 0, 0, 0, 0, 1, 9, 0);
        vt[4] = mk("duplicates", 16'h00AA, 4, 16'h00AA, 40, 16'h00AA, -1, 0, -1, 0, -1, -1, 0, 0, 1, 4, 0, 0, 2);
        vt[5] = mk("edges_stall", 16'h7777, 55, 16'h7777, 0, 16'h0000, -1, 0, -1, 0, -1, -1, 3, 5, 1, 55, 1, 0, 1);

        rst = 1'b1; req_valid = 0; req_id = '0; row_valid = 0; row_data = '0; row_ena = '0; res_ready = 0;
        tick();
        chk("reset req_ready", req_ready, 0);
        chk("reset outputs", {row_ready, res_valid, res_hit, res_hit_idx, res_free, res_free_idx, res_multi, res_cnt}, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("req_ready after release", req_ready, 1);
        chk("res_valid after release", res_valid, 0);

        // Reset mid-scan: stale beat 0 holds the key and must not leak into the next lookup
        fill_bg();
        g_ids[0] = 16'h4242;
        start_req("midscan", 16'h4242);
        send_beat_of("midscan", 0);
        send_beat_of("midscan", 1);
        rst = 1'b1;
        #1;
        chk("midscan reset req_ready", req_ready, 0);
        chk("midscan reset row_ready", row_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("midscan req_ready after release", req_ready, 1);
        chk("midscan res_valid after release", res_valid, 0);
        fill_bg();
        run_lookup("after_reset", 16'h4242, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            fill_bg();
            for (int p = 0; p < 4; p++) if (vt[i].ps[p] >= 0) g_ids[vt[i].ps[p]] = vt[i].pv[p];
            for (int p = 0; p < 2; p++) if (vt[i].ds[p] >= 0) g_ena[vt[i].ds[p]] = 1'b0;
            if (vt[i].hold > 0) begin
                // Row beats offered while idle must be ignored
                row_valid = 1'b1; row_data = {ENTRIES{vt[i].key}}; row_ena = '1;
                repeat (3) begin
                    chk({vt[i].name, " idle row_ready"}, row_ready, 0);
                    tick();
                end
                row_valid = 1'b0;
            end
            run_lookup(vt[i].name, vt[i].key, vt[i].gap, vt[i].hold,
                       vt[i].eh, vt[i].ehi, vt[i].ef, vt[i].efi, vt[i].ec);
        end

        for (int n = 0; n < 40; n++) begin
            key = ($urandom_range(0, 7) == 0) ? 16'h0000 : ID_W'($urandom);
            for (int s = 0; s < SLOTS; s++) begin
                case ($urandom_range(0, 19))
                    0:       g_ids[s] = key;
                    1:       g_ids[s] = 16'h0000;
                    default: g_ids[s] = ID_W'($urandom);
                endcase
                g_ena[s] = ($urandom_range(0, 7) != 0);
            end
            gap = $urandom_range(0, 2);
            hold = $urandom_range(0, 3);
            model(key, h, hi, f, fi, c);
            run_lookup("random", key, gap, hold, h, hi, f, fi, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
